// File: rtl/pll_sup_pkg.sv
// Shared types and helpers for the PLL lock supervisor: state encodings,
// default parameter values and the phase-counter width calculation.
package pll_sup_pkg;

  typedef enum logic [2:0] {
    ST_RESET_PLL = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAILED    = 3'd4
  } sup_state_e;

  localparam int unsigned DEF_RST_CYCLES    = 16;
  localparam int unsigned DEF_LOCK_TIMEOUT  = 50000;
  localparam int unsigned DEF_STABLE_CYCLES = 1024;
  localparam int unsigned DEF_MAX_RETRIES   = 4;
  localparam int unsigned DEF_CNT_W         = 8;

  // One shared phase counter only ever holds values up to (longest phase - 1).
  function automatic int unsigned cnt_width(input int unsigned a,
                                            input int unsigned b,
                                            input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/pll_lock_supervisor_sync_2ff.sv
// Single-bit two-flop synchronizer with synchronous active-high clear.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_q, sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/pll_lock_supervisor.sv
// Drives PLL reset, qualifies lock over a stability window, and releases the
// downstream reset only while lock is stable; retries with a bounded count.
module pll_lock_supervisor
  import pll_sup_pkg::*;
#(
  parameter int unsigned RST_CYCLES    = DEF_RST_CYCLES,
  parameter int unsigned LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT,
  parameter int unsigned STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int unsigned MAX_RETRIES   = DEF_MAX_RETRIES,
  parameter int unsigned CNT_W         = DEF_CNT_W
) (
  input  logic             refclk,
  input  logic             rst,
  input  logic             pll_locked,
  input  logic             clear_err,
  output logic             pll_rst,
  output logic             sys_rst,
  output logic             ready,
  output logic             error,
  output logic [CNT_W-1:0] lock_loss_cnt,
  output logic [2:0]       state_o
);

  localparam int unsigned CW = cnt_width(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);
  localparam int unsigned RW = $clog2(MAX_RETRIES + 1);

  localparam logic [CW-1:0]    RST_LAST  = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0]    TO_LAST   = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0]    STB_LAST  = CW'(STABLE_CYCLES - 1);
  localparam logic [RW-1:0]    RETRY_LIM = RW'(MAX_RETRIES);
  localparam logic [CNT_W-1:0] LOSS_MAX  = {CNT_W{1'b1}};

  logic lk;

  sup_state_e       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [RW-1:0]    retry_q, retry_d;
  logic [CNT_W-1:0] loss_q, loss_d;
  logic             pll_rst_q, pll_rst_d;
  logic             sys_rst_q, sys_rst_d;
  logic             ready_q, ready_d;
  logic             error_q, error_d;

  sync_2ff u_lock_sync (
    .clk (refclk),
    .rst (rst),
    .d   (pll_locked),
    .q   (lk)
  );

  // State, counters and output flops; outputs are decoded from the next state
  // so they change on the same edge as state_q and cannot glitch.
  always_ff @(posedge refclk) begin
    if (rst) begin
      state_q   <= ST_RESET_PLL;
      cnt_q     <= '0;
      retry_q   <= '0;
      loss_q    <= '0;
      pll_rst_q <= 1'b1;
      sys_rst_q <= 1'b1;
      ready_q   <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      retry_q   <= retry_d;
      loss_q    <= loss_d;
      pll_rst_q <= pll_rst_d;
      sys_rst_q <= sys_rst_d;
      ready_q   <= ready_d;
      error_q   <= error_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    retry_d = retry_q;
    loss_d  = loss_q;
    unique case (state_q)
      ST_RESET_PLL: begin
        if (cnt_q == RST_LAST) begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_WAIT_LOCK: begin
        // Lock takes priority over a timeout landing on the same cycle.
        if (lk) begin
          state_d = ST_STABLE;
          cnt_d   = '0;
        end else if (cnt_q == TO_LAST) begin
          cnt_d   = '0;
          retry_d = retry_q + RW'(1);
          state_d = (retry_d == RETRY_LIM) ? ST_FAILED : ST_RESET_PLL;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_STABLE: begin
        if (!lk) begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == STB_LAST) begin
          state_d = ST_RUN;
          cnt_d   = '0;
          retry_d = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_RUN: begin
        if (!lk) begin
          state_d = ST_RESET_PLL;
          cnt_d   = '0;
          if (loss_q != LOSS_MAX) loss_d = loss_q + CNT_W'(1);
        end
      end
      ST_FAILED: begin
        if (clear_err) begin
          state_d = ST_RESET_PLL;
          cnt_d   = '0;
          retry_d = '0;
        end
      end
      default: begin
        state_d = ST_RESET_PLL;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    pll_rst_d = 1'b1;
    sys_rst_d = 1'b1;
    ready_d   = 1'b0;
    error_d   = 1'b0;
    unique case (state_d)
      ST_WAIT_LOCK, ST_STABLE: pll_rst_d = 1'b0;
      ST_RUN: begin
        pll_rst_d = 1'b0;
        sys_rst_d = 1'b0;
        ready_d   = 1'b1;
      end
      ST_FAILED: error_d = 1'b1;
      default: ;
    endcase
  end

  assign pll_rst       = pll_rst_q;
  assign sys_rst       = sys_rst_q;
  assign ready         = ready_q;
  assign error         = error_q;
  assign lock_loss_cnt = loss_q;
  assign state_o       = state_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Self-checking bench for pll_lock_supervisor: scenario tasks plus a per-cycle
// behavioural model driven by the same inputs.
module tb_pll_lock_supervisor;

  localparam int RC = 4, LT = 20, SC = 8, MR = 2, CW = 2;
  localparam int LOSS_SAT = (1 << CW) - 1;

  logic refclk = 1'b0, rst = 1'b1, pll_locked = 1'b0, clear_err = 1'b0;
  logic pll_rst, sys_rst, ready, error;
  logic [CW-1:0] lock_loss_cnt;
  logic [2:0] state_o;

  int n_chk = 0, n_fail = 0, exp_loss = 0;
  bit chk_en = 1'b0;

  pll_lock_supervisor #(
    .RST_CYCLES(RC), .LOCK_TIMEOUT(LT), .STABLE_CYCLES(SC),
    .MAX_RETRIES(MR), .CNT_W(CW)
  ) dut (
    .refclk(refclk), .rst(rst), .pll_locked(pll_locked), .clear_err(clear_err),
    .pll_rst(pll_rst), .sys_rst(sys_rst), .ready(ready), .error(error),
    .lock_loss_cnt(lock_loss_cnt), .state_o(state_o)
  );

  always #5 refclk = ~refclk;

  // Behavioural model: phase names with the documented encodings, time spent
  // in each phase, failed attempts and lock-loss events.
  localparam int P_RST = 0, P_WAIT = 1, P_STAB = 2, P_RUN = 3, P_FAIL = 4;
  int m_phase = P_RST, m_age = 0, m_fails = 0, m_loss = 0;
  bit lk_hist[2] = '{1'b0, 1'b0};

  always @(posedge refclk) begin
    bit lk_now;
    lk_now = lk_hist[1];
    if (rst) begin
      lk_hist = '{1'b0, 1'b0};
      m_phase = P_RST; m_age = 0; m_fails = 0; m_loss = 0;
    end else begin
      lk_hist[1] = lk_hist[0];
      lk_hist[0] = pll_locked;
      case (m_phase)
        P_RST: begin
          m_age++;
          if (m_age == RC) begin m_phase = P_WAIT; m_age = 0; end
        end
        P_WAIT: begin
          if (lk_now) begin m_phase = P_STAB; m_age = 0; end
          else begin
            m_age++;
            if (m_age == LT) begin
              m_fails++;
              m_phase = (m_fails == MR) ? P_FAIL : P_RST;
              m_age = 0;
            end
          end
        end
        P_STAB: begin
          if (!lk_now) begin m_phase = P_WAIT; m_age = 0; end
          else begin
            m_age++;
            if (m_age == SC) begin m_phase = P_RUN; m_age = 0; m_fails = 0; end
          end
        end
        P_RUN: begin
          if (!lk_now) begin
            m_loss = (m_loss < LOSS_SAT) ? m_loss + 1 : LOSS_SAT;
            m_phase = P_RST; m_age = 0;
          end
        end
        default: begin
          if (clear_err) begin m_phase = P_RST; m_age = 0; m_fails = 0; end
        end
      endcase
    end
  end

  always @(negedge refclk) begin
    if (chk_en) begin
      n_chk++;
      if (state_o !== 3'(m_phase)) begin
        n_fail++; $display("FAIL model_state t=%0t got %0d expected %0d", $time, state_o, m_phase);
      end
      n_chk++;
      if (pll_rst !== (m_phase == P_RST || m_phase == P_FAIL)) begin
        n_fail++; $display("FAIL model_pll_rst t=%0t got %b phase %0d", $time, pll_rst, m_phase);
      end
      n_chk++;
      if (sys_rst !== (m_phase != P_RUN)) begin
        n_fail++; $display("FAIL model_sys_rst t=%0t got %b phase %0d", $time, sys_rst, m_phase);
      end
      n_chk++;
      if (ready !== (m_phase == P_RUN)) begin
        n_fail++; $display("FAIL model_ready t=%0t got %b phase %0d", $time, ready, m_phase);
      end
      n_chk++;
      if (error !== (m_phase == P_FAIL)) begin
        n_fail++; $display("FAIL model_error t=%0t got %b phase %0d", $time, error, m_phase);
      end
      n_chk++;
      if (lock_loss_cnt !== CW'(m_loss)) begin
        n_fail++; $display("FAIL model_loss_cnt t=%0t got %0d expected %0d", $time, lock_loss_cnt, m_loss);
      end
    end
  end

  task automatic bump_loss();
    exp_loss = (exp_loss < LOSS_SAT) ? exp_loss + 1 : LOSS_SAT;
  endtask

  task automatic test_reset();
    rst = 1'b1; pll_locked = 1'b0; clear_err = 1'b0;
    repeat (3) @(negedge refclk);
    chk_en = 1'b1;
    n_chk++;
    if (state_o !== 3'd0 || pll_rst !== 1'b1 || sys_rst !== 1'b1 || ready !== 1'b0 ||
        error !== 1'b0 || lock_loss_cnt !== '0) begin
      n_fail++;
      $display("FAIL reset_state got st=%0d prst=%b srst=%b rdy=%b err=%b loss=%0d expected 0 1 1 0 0 0",
               state_o, pll_rst, sys_rst, ready, error, lock_loss_cnt);
    end
    exp_loss = 0;
  endtask

  task automatic test_nominal();
    int w, lat;
    rst = 1'b0;
    w = 0;
    for (int i = 0; i < 50 && pll_rst; i++) begin w++; @(negedge refclk); end
    n_chk++;
    if (w != RC) begin n_fail++; $display("FAIL nominal_pll_rst_width got %0d expected %0d", w, RC); end
    repeat (6) @(negedge refclk);
    pll_locked = 1'b1;
    lat = 0;
    for (int i = 0; i < 60 && !ready; i++) begin @(negedge refclk); lat++; end
    n_chk++;
    if (!ready || lat < SC + 1 || lat > SC + 3) begin
      n_fail++; $display("FAIL nominal_ready_latency got %0d (ready=%b) expected %0d..%0d", lat, ready, SC + 1, SC + 3);
    end
    n_chk++;
    if (sys_rst !== 1'b0) begin n_fail++; $display("FAIL nominal_sys_rst got %b expected 0", sys_rst); end
  endtask

  task automatic test_lock_loss();
    int lat, w;
    clear_err = 1'b1;
    @(negedge refclk);
    clear_err = 1'b0;
    n_chk++;
    if (state_o !== 3'd3) begin n_fail++; $display("FAIL clear_err_ignored got %0d expected 3", state_o); end
    pll_locked = 1'b0;
    lat = 0;
    for (int i = 0; i < 10 && ready; i++) begin @(negedge refclk); lat++; end
    bump_loss();
    n_chk++;
    if (ready || lat > 3 || sys_rst !== 1'b1) begin
      n_fail++; $display("FAIL loss_latency got %0d sys_rst=%b expected <=3 and 1", lat, sys_rst);
    end
    n_chk++;
    if (lock_loss_cnt !== CW'(exp_loss)) begin
      n_fail++; $display("FAIL loss_count got %0d expected %0d", lock_loss_cnt, exp_loss);
    end
    w = 0;
    for (int i = 0; i < 50 && pll_rst; i++) begin w++; @(negedge refclk); end
    n_chk++;
    if (w != RC) begin n_fail++; $display("FAIL loss_pll_rst_width got %0d expected %0d", w, RC); end
    pll_locked = 1'b1;
    for (int i = 0; i < 60 && !ready; i++) @(negedge refclk);
    n_chk++;
    if (ready !== 1'b1) begin n_fail++; $display("FAIL loss_relock ready got %b expected 1", ready); end
  endtask

  task automatic test_glitch();
    int lat, pulses;
    pll_locked = 1'b0;
    for (int i = 0; i < 10 && ready; i++) @(negedge refclk);
    bump_loss();
    for (int i = 0; i < 50 && pll_rst; i++) @(negedge refclk);
    pulses = 0;
    pll_locked = 1'b1;
    repeat (5) begin @(negedge refclk); pulses += int'(pll_rst); end
    pll_locked = 1'b0;
    @(negedge refclk); pulses += int'(pll_rst);
    pll_locked = 1'b1;
    lat = 0;
    for (int i = 0; i < 60 && !ready; i++) begin @(negedge refclk); lat++; pulses += int'(pll_rst); end
    n_chk++;
    if (pulses != 0) begin n_fail++; $display("FAIL glitch_extra_pll_rst got %0d cycles expected 0", pulses); end
    n_chk++;
    if (!ready || lat < SC + 1 || lat > SC + 3) begin
      n_fail++; $display("FAIL glitch_ready_latency got %0d expected %0d..%0d", lat, SC + 1, SC + 3);
    end
  endtask

  task automatic test_timeout();
    int w;
    pll_locked = 1'b0;
    for (int i = 0; i < 10 && !pll_rst; i++) @(negedge refclk);
    bump_loss();
    for (int a = 0; a < MR; a++) begin
      w = 0;
      for (int i = 0; i < 50 && pll_rst; i++) begin w++; @(negedge refclk); end
      n_chk++;
      if (w != RC) begin n_fail++; $display("FAIL timeout_pulse%0d got %0d expected %0d", a, w, RC); end
      w = 0;
      for (int i = 0; i < 100 && !pll_rst; i++) begin w++; @(negedge refclk); end
      n_chk++;
      if (w != LT) begin n_fail++; $display("FAIL timeout_wait%0d got %0d expected %0d", a, w, LT); end
    end
    repeat (3) @(negedge refclk);
    n_chk++;
    if (error !== 1'b1 || state_o !== 3'd4 || pll_rst !== 1'b1 || sys_rst !== 1'b1) begin
      n_fail++; $display("FAIL failed_state got err=%b st=%0d prst=%b srst=%b expected 1 4 1 1",
                         error, state_o, pll_rst, sys_rst);
    end
    clear_err = 1'b1;
    @(negedge refclk);
    clear_err = 1'b0;
    n_chk++;
    if (state_o !== 3'd0 || error !== 1'b0 || pll_rst !== 1'b1 || lock_loss_cnt !== CW'(exp_loss)) begin
      n_fail++; $display("FAIL clear_err_restart got st=%0d err=%b prst=%b loss=%0d expected 0 0 1 %0d",
                         state_o, error, pll_rst, lock_loss_cnt, exp_loss);
    end
    pll_locked = 1'b1;
    for (int i = 0; i < 60 && !ready; i++) @(negedge refclk);
    n_chk++;
    if (ready !== 1'b1) begin n_fail++; $display("FAIL restart_ready got %b expected 1", ready); end
  endtask

  task automatic test_saturation();
    for (int e = 0; e < 5; e++) begin
      pll_locked = 1'b0;
      for (int i = 0; i < 10 && ready; i++) @(negedge refclk);
      bump_loss();
      n_chk++;
      if (lock_loss_cnt !== CW'(exp_loss)) begin
        n_fail++; $display("FAIL sat_event%0d got %0d expected %0d", e, lock_loss_cnt, exp_loss);
      end
      pll_locked = 1'b1;
      for (int i = 0; i < 60 && !ready; i++) @(negedge refclk);
    end
    n_chk++;
    if (lock_loss_cnt !== CW'(LOSS_SAT)) begin
      n_fail++; $display("FAIL sat_final got %0d expected %0d", lock_loss_cnt, LOSS_SAT);
    end
  endtask

  task automatic test_mid_reset();
    for (int pass = 0; pass < 2; pass++) begin
      if (pass == 1) begin
        rst = 1'b0;
        pll_locked = 1'b1;
        for (int i = 0; i < 40 && state_o !== 3'd2; i++) @(negedge refclk);
        n_chk++;
        if (state_o !== 3'd2) begin n_fail++; $display("FAIL reach_stable got %0d expected 2", state_o); end
      end
      rst = 1'b1;
      @(negedge refclk);
      exp_loss = 0;
      n_chk++;
      if (state_o !== 3'd0 || pll_rst !== 1'b1 || sys_rst !== 1'b1 || lock_loss_cnt !== '0 || error !== 1'b0) begin
        n_fail++; $display("FAIL mid_reset%0d got st=%0d prst=%b srst=%b loss=%0d err=%b expected 0 1 1 0 0",
                           pass, state_o, pll_rst, sys_rst, lock_loss_cnt, error);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_random();
    int hold;
    hold = 0;
    for (int c = 0; c < 1500; c++) begin
      if (hold == 0) begin
        pll_locked = ~pll_locked;
        hold = $urandom_range(1, 60);
      end
      hold--;
      clear_err = ($urandom_range(0, 15) == 0);
      @(negedge refclk);
    end
    clear_err = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_nominal();
    test_lock_loss();
    test_glitch();
    test_timeout();
    test_saturation();
    test_mid_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
